// File: rtl/char_pixel_shifter_pkg.sv
// Shared constants and fetch-state encoding for the character pixel shifter.
package char_pixel_shifter_pkg;
    localparam int PIX_BITS      = 4;
    localparam int PAL_BITS      = 4;
    localparam int PIX_PER_TILE  = 8;
    localparam int WORDS_PER_ROW = 2;
    localparam int ROW_BITS      = PIX_BITS * PIX_PER_TILE;
    localparam int WORD_BITS     = ROW_BITS / WORDS_PER_ROW;
    localparam int CNT_BITS      = $clog2(PIX_PER_TILE + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_LO,
        ST_REQ_HI,
        ST_CAPTURE,
        ST_HOLD
    } fetch_state_t;
endpackage

// File: rtl/char_pixel_serializer.sv
// Eight-pixel shift register with valid/ready output; pixel 0 sits in the top nibble.
module char_pixel_serializer
    import char_pixel_shifter_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_flush,
    input  logic                         i_load,
    input  logic [ROW_BITS-1:0]          i_pixels,
    input  logic [PAL_BITS-1:0]          i_palette,
    input  logic                         i_pixel_ready,
    output logic                         o_pixel_valid,
    output logic [PAL_BITS+PIX_BITS-1:0] o_pixel_out,
    output logic                         o_loadable
);
    logic [CNT_BITS-1:0] r_count;
    logic [ROW_BITS-1:0] r_shift;
    logic [PAL_BITS-1:0] r_pal;
    logic                w_xfer;

    assign o_pixel_valid = (r_count != '0);
    assign o_pixel_out   = {r_pal, r_shift[ROW_BITS-1 -: PIX_BITS]};
    assign w_xfer        = o_pixel_valid && i_pixel_ready;
    // Loading while the last pixel leaves keeps tile-to-tile output gapless.
    assign o_loadable    = (r_count == '0) || ((r_count == CNT_BITS'(1)) && i_pixel_ready);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
            r_shift <= '0;
            r_pal   <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_BITS'(PIX_PER_TILE);
            r_shift <= i_pixels;
            r_pal   <= i_palette;
        end else if (w_xfer) begin
            r_count <= r_count - CNT_BITS'(1);
            r_shift <= {r_shift[ROW_BITS-PIX_BITS-1:0], {PIX_BITS{1'b0}}};
        end
    end
endmodule

// File: rtl/char_pixel_shifter.sv
// Fetches one 8-pixel character row as two ROM words and streams it out with palette.
module char_pixel_shifter
    import char_pixel_shifter_pkg::*;
#(
    parameter int TILE_BITS = 6,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tile_valid,
    output logic                 tile_ready,
    input  logic [TILE_BITS-1:0] tile_index,
    input  logic [2:0]           tile_row,
    input  logic [3:0]           tile_palette,
    input  logic                 flush,
    output logic [ADDR_BITS-1:0] rom_address,
    input  logic [15:0]          rom_data,
    output logic                 pixel_valid,
    input  logic                 pixel_ready,
    output logic [7:0]           pixel_out
);
    fetch_state_t          r_state, w_next;
    logic [TILE_BITS-1:0]  r_tile;
    logic [2:0]            r_row;
    logic [PAL_BITS-1:0]   r_pal;
    logic [WORD_BITS-1:0]  r_lo_word;
    logic [ROW_BITS-1:0]   r_stage_pix;
    logic [PAL_BITS-1:0]   r_stage_pal;
    logic [ADDR_BITS-1:0]  r_rom_address;
    logic                  w_accept, w_load, w_loadable;
    logic [ROW_BITS-1:0]   w_load_pix;
    logic [PAL_BITS-1:0]   w_load_pal;

    assign tile_ready  = reset_n && (r_state == ST_IDLE) && !flush;
    assign w_accept    = tile_valid && tile_ready;
    assign rom_address = r_rom_address;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_pix = {r_lo_word, rom_data};
        w_load_pal = r_pal;
        case (r_state)
            ST_IDLE:    if (w_accept) w_next = ST_REQ_LO;
            ST_REQ_LO:  w_next = ST_REQ_HI;
            ST_REQ_HI:  w_next = ST_CAPTURE;
            ST_CAPTURE: begin
                if (w_loadable) begin
                    w_load = 1'b1;
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_load_pix = r_stage_pix;
                w_load_pal = r_stage_pal;
                if (w_loadable) begin
                    w_load = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default:    w_next = ST_IDLE;
        endcase
        if (flush) begin
            w_next = ST_IDLE;
            w_load = 1'b0;
        end
    end

    // Address is registered one state ahead so the ROM's one-cycle latency
    // lines up: low word arrives in REQ_HI, high word in CAPTURE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tile        <= '0;
            r_row         <= '0;
            r_pal         <= '0;
            r_lo_word     <= '0;
            r_stage_pix   <= '0;
            r_stage_pal   <= '0;
            r_rom_address <= '0;
        end else begin
            if (w_accept) begin
                r_tile        <= tile_index;
                r_row         <= tile_row;
                r_pal         <= tile_palette;
                r_rom_address <= {tile_index, tile_row, 1'b0};
            end
            if (r_state == ST_REQ_LO && !flush)
                r_rom_address <= {r_tile, r_row, 1'b1};
            if (r_state == ST_REQ_HI)
                r_lo_word <= rom_data;
            if (flush) begin
                r_stage_pix <= '0;
                r_stage_pal <= '0;
            end else if (r_state == ST_CAPTURE && !w_loadable) begin
                r_stage_pix <= {r_lo_word, rom_data};
                r_stage_pal <= r_pal;
            end
        end
    end

    char_pixel_serializer u_ser (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_flush       (flush),
        .i_load        (w_load),
        .i_pixels      (w_load_pix),
        .i_palette     (w_load_pal),
        .i_pixel_ready (pixel_ready),
        .o_pixel_valid (pixel_valid),
        .o_pixel_out   (pixel_out),
        .o_loadable    (w_loadable)
    );
endmodule

// File: tb/tb_char_pixel_shifter.sv
// Scoreboard bench: expected pixels pushed at tile acceptance, popped by a negedge monitor.
module tb_char_pixel_shifter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tile_valid = 1'b0;
    logic        tile_ready;
    logic [5:0]  tile_index = '0;
    logic [2:0]  tile_row = '0;
    logic [3:0]  tile_palette = '0;
    logic        flush = 1'b0;
    logic [9:0]  rom_address;
    logic [15:0] rom_data;
    logic        pixel_valid;
    logic        pixel_ready = 1'b0;
    logic [7:0]  pixel_out;

    logic [15:0] mem [0:1023];
    logic [7:0]  exp_q [$];
    int          total = 0, bad = 0;
    int          run = 0, max_run = 0, valid_seen = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_out = '0;
    bit          rand_rdy = 1'b0;
    bit          rdy_fixed = 1'b0;

    char_pixel_shifter #(.TILE_BITS(6), .ADDR_BITS(10)) dut (
        .clk(clk), .reset_n(reset_n), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_index(tile_index), .tile_row(tile_row), .tile_palette(tile_palette),
        .flush(flush), .rom_address(rom_address), .rom_data(rom_data),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_out(pixel_out)
    );

    always #5 clk = ~clk;

    // Synchronous-read ROM: data for an address appears one cycle later.
    always @(posedge clk) rom_data <= mem[rom_address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: row occupies two consecutive words, pixel k in nibble (3 - k%4) of word k/4.
    function automatic logic [7:0] ref_pix(input int t, input int r, input int p, input int k);
        int w, c;
        w = int'(mem[t * 16 + r * 2 + k / 4]);
        c = (w >> (12 - 4 * (k % 4))) & 15;
        return {p[3:0], c[3:0]};
    endfunction

    // Sole writer of pixel_ready, offset from the main thread's #1 writes.
    initial forever begin
        @(posedge clk); #2;
        pixel_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    always @(negedge clk) begin
        if (!reset_n || flush) begin
            exp_q.delete();
            run = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(pixel_valid), 32'd1);
                chk("stall_hold", 32'(pixel_out), 32'(prev_out));
            end
            if (pixel_valid && pixel_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pixel: got %0h expected none at %0t", pixel_out, $time);
                end else begin
                    chk("pixel", 32'(pixel_out), 32'(exp_q.pop_front()));
                end
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            prev_stall = pixel_valid && !pixel_ready;
            prev_out   = pixel_out;
            if (pixel_valid) valid_seen++;
        end
    end

    task automatic send_tile(input int t, input int r, input int p);
        bit done = 1'b0;
        tile_index = 6'(t); tile_row = 3'(r); tile_palette = 4'(p); tile_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (tile_ready) begin
                for (int k = 0; k < 8; k++) exp_q.push_back(ref_pix(t, r, p, k));
                done = 1'b1;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no accept expected accept at %0t", $time);
        end
        @(posedge clk); #1;
        tile_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || pixel_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[10'h056] = 16'h0123;
        mem[10'h057] = 16'h4567;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tile_ready", 32'(tile_ready), 32'd0);
        chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        chk("rst_rom_address", 32'(rom_address), 32'd0);
        chk("rst_pixel_out", 32'(pixel_out), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1; rdy_fixed = 1'b1;
        @(posedge clk); #1;

        // known ROM words: address order and first-pixel latency
        send_tile(5, 3, 4'hA);
        @(negedge clk); chk("addr_lo", 32'(rom_address), 32'h056);
        @(negedge clk); chk("addr_hi", 32'(rom_address), 32'h057);
        @(negedge clk); chk("capture_no_valid", 32'(pixel_valid), 32'd0);
        @(negedge clk);
        chk("first_valid", 32'(pixel_valid), 32'd1);
        chk("ready_back", 32'(tile_ready), 32'd1);
        chk("first_pixel", 32'(pixel_out), 32'hA0);
        drain();

        // back-to-back tiles: 16 gapless transfers
        max_run = 0;
        send_tile(12, 1, 3);
        send_tile(40, 7, 9);
        drain();
        chk("b2b_run", 32'(max_run), 32'd16);

        // consumer stall: second tile parks in staging
        rdy_fixed = 1'b0;
        @(posedge clk); #1;
        send_tile(7, 2, 5);
        send_tile(33, 6, 14);
        repeat (20) @(negedge clk);
        chk("hold_tile_ready", 32'(tile_ready), 32'd0);
        chk("hold_valid", 32'(pixel_valid), 32'd1);
        chk("hold_pixel", 32'(pixel_out), 32'(ref_pix(7, 2, 5, 0)));
        max_run = 0;
        @(posedge clk); #1;
        rdy_fixed = 1'b1;
        drain();
        chk("stall_run", 32'(max_run), 32'd16);

        // flush with a pending request and queued pixels
        rdy_fixed = 1'b0;
        @(posedge clk); #1;
        send_tile(21, 4, 2);
        repeat (6) @(posedge clk);
        #1;
        tile_index = 6'd50; tile_row = 3'd1; tile_palette = 4'd6; tile_valid = 1'b1; flush = 1'b1;
        @(negedge clk); chk("flush_no_ready", 32'(tile_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; tile_valid = 1'b0; rdy_fixed = 1'b1;
        @(negedge clk); chk("flush_valid_low", 32'(pixel_valid), 32'd0);
        valid_seen = 0;
        repeat (20) @(negedge clk);
        chk("flush_no_stale", 32'(valid_seen), 32'd0);
        @(posedge clk); #1;

        // reset during REQ_HI
        send_tile(9, 5, 11);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk); chk("rst_mid_ready", 32'(tile_ready), 32'd0);
        @(negedge clk);
        chk("rst_mid_valid", 32'(pixel_valid), 32'd0);
        chk("rst_mid_addr", 32'(rom_address), 32'd0);
        chk("rst_mid_pixel", 32'(pixel_out), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        valid_seen = 0;
        repeat (8) @(negedge clk);
        chk("rst_no_stale", 32'(valid_seen), 32'd0);
        @(posedge clk); #1;
        send_tile(62, 0, 15);
        drain();

        // random tiles with random consumer back-pressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 200; n++) begin
            send_tile(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();
        rand_rdy = 1'b0;
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/char_pixel_shifter.md
CHAR_PIXEL_SHIFTER -- requirements
Module: char_pixel_shifter

Interface
REQ-001 Parameter TILE_BITS, default 6, width of tile index (64 tiles of 8x8 4bpp).
REQ-002 Parameter ADDR_BITS, default 10, width of char ROM word address; SHALL equal TILE_BITS+4.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 tile_valid  in  1  tile request present.
REQ-006 tile_ready  out  1  request accepted when tile_valid && tile_ready at a rising edge.
REQ-007 tile_index  in  TILE_BITS  character to fetch.
REQ-008 tile_row  in  3  pixel row within character, 0..7.
REQ-009 tile_palette  in  4  palette, passed through with pixels.
REQ-010 flush  in  1  synchronous discard of all in-flight work (line start).
REQ-011 rom_address  out  ADDR_BITS  char ROM word address, driven from registers only.
REQ-012 rom_data  in  16  char ROM read data, valid one cycle after rom_address.
REQ-013 pixel_valid  out  1  pixel_out holds a pixel.
REQ-014 pixel_ready  in  1  consumer takes pixel when pixel_valid && pixel_ready.
REQ-015 pixel_out  out  8  {palette[3:0], colour[3:0]}.

Function
REQ-016 ROM address SHALL be {tile_index, tile_row, half}; half 0 = pixels 0-3, half 1 = pixels 4-7.
REQ-017 Within each word, pixel n (of 4) SHALL occupy bits [15-4n:12-4n]; pixel 0 in [15:12].
REQ-018 Fetch FSM states: IDLE, REQ_LO, REQ_HI, CAPTURE, HOLD.
REQ-019 tile_ready SHALL be 1 only in IDLE with flush low.
REQ-020 IDLE -> REQ_LO on accept; tile_index/row/palette latched.
REQ-021 REQ_LO: rom_address = {tile,row,0}; -> REQ_HI.
REQ-022 REQ_HI: rom_address = {tile,row,1}; rom_data (low word) latched; -> CAPTURE.
REQ-023 CAPTURE: if shifter loadable, load {lo, rom_data} and palette into shifter and -> IDLE; else store into staging register and -> HOLD.
REQ-024 Shifter loadable = shifter count 0, or count 1 with a pixel transfer in the same cycle (zero-bubble back-to-back tiles).
REQ-025 HOLD: load staging into shifter when loadable, -> IDLE; otherwise remain.
REQ-026 First pixel_valid SHALL occur 4 cycles after the accepting edge when the shifter is empty; tile_ready reasserts in that same cycle.
REQ-027 pixel_valid = (shifter count != 0); count loads to 8, decrements by 1 per transfer.
REQ-028 pixel_out SHALL be stable while pixel_valid && !pixel_ready.
REQ-029 Pixels SHALL emit in order 0..7 with no gaps while pixel_ready is held high and requests keep coming.
REQ-030 flush high: FSM -> IDLE, shifter count -> 0, staging discarded next cycle; flush SHALL take priority over accept, load and transfer in the same cycle.
REQ-031 rom_address outside REQ_LO/REQ_HI SHALL hold its last value (no spurious toggling required).

Reset
REQ-032 reset_n low at a rising edge: FSM IDLE, shifter count 0, pixel_valid 0, tile_ready 0 during reset, rom_address 0, pixel_out 0, staging and latched tile cleared.
REQ-033 Reset mid-fetch or mid-shift SHALL abandon the operation; no pixel of it SHALL appear after reset releases.

Structure
REQ-034 Shared package: FSM state enumeration, pixel width (4), pixels per tile (8), words per row (2).
REQ-035 One natural sub-module: char_pixel_serializer (8-pixel shift register, count and valid/ready), instantiated once.

Verification
REQ-036 ROM model mem[0x056]=16'h0123, mem[0x057]=16'h4567; tile 5, row 3, palette 0xA, pixel_ready=1 -> addresses 0x056 then 0x057; pixels A0..A7 starting 4 cycles after accept.
REQ-037 Two tiles presented back to back with pixel_ready=1 -> 16 consecutive pixel_valid cycles, no bubble between pixel 7 and the next pixel 0.
REQ-038 pixel_ready=0 for 20 cycles after the first tile -> FSM holds in HOLD with tile 2 staged, tile_ready 0; on release all 16 pixels arrive in order.
REQ-039 flush asserted with tile_valid high and pixels pending -> tile not accepted, pixel_valid 0 next cycle, no stale pixels later.
REQ-040 reset_n low during REQ_HI -> all outputs at reset values; after release a new tile gives correct pixels only.
REQ-041 Random pixel_ready toggling over 200 tiles -> pixel stream equals reference model; pixel_out never changes while stalled.
